// File: rtl/core_dout_pkg.sv
// Shared packet-format constants and channel state encoding for the core output multiplexer.
package core_dout_pkg;
    localparam int START_BIT      = 0;
    localparam int EQUAL_BIT      = 1;
    localparam int BATCH_DONE_BIT = 0;
    localparam int SHORT_WORDS    = 2;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_CAPTURE,
        CH_FULL
    } ch_state_t;
endpackage

// File: rtl/core_dout_capture.sv
// One core channel: registers the core word, assembles a packet into its buffer and
// holds it until the arbiter has read the last word out.
module core_dout_capture
    import core_dout_pkg::*;
#(
    parameter int DW          = 4,
    parameter int LONG_WORDS  = 6,
    parameter int SHORT_WORDS = core_dout_pkg::SHORT_WORDS
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [DW-1:0]                   din,
    input  logic                            rel,
    output logic                            full,
    output logic                            ready,
    output logic                            err,
    output logic                            is_long,
    output logic [LONG_WORDS-1:0][DW-1:0]   words
);
    localparam int CW = $clog2(LONG_WORDS);

    logic [DW-1:0] din_p0;
    logic [CW-1:0] cnt;
    ch_state_t     state;
    int            len_now;
    logic          last_store;

    // Packet length is known from the word at index 1 onward; before that it is taken live.
    always_comb begin
        len_now = SHORT_WORDS;
        if (cnt == CW'(1))
            len_now = din_p0[EQUAL_BIT] ? LONG_WORDS : SHORT_WORDS;
        else if (is_long)
            len_now = LONG_WORDS;
        last_store = (int'(cnt) == len_now - 1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            din_p0  <= '0;
            state   <= CH_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            err     <= 1'b0;
            is_long <= 1'b0;
        end else begin
            din_p0 <= din;
            case (state)
                CH_IDLE: begin
                    if (din_p0[START_BIT]) begin
                        cnt   <= CW'(1);
                        ready <= 1'b0;
                        state <= CH_CAPTURE;
                    end
                end
                CH_CAPTURE: begin
                    if (cnt == CW'(1)) begin
                        is_long <= din_p0[EQUAL_BIT];
                        if (!din_p0[EQUAL_BIT] && !din_p0[BATCH_DONE_BIT])
                            err <= 1'b1;
                    end
                    if (last_store) begin
                        cnt   <= '0;
                        state <= CH_FULL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CH_FULL: begin
                    if (din_p0[START_BIT])
                        err <= 1'b1;
                    if (rel) begin
                        ready <= 1'b1;
                        state <= CH_IDLE;
                    end
                end
                default: state <= CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == CH_IDLE && din_p0[START_BIT])
            words[0] <= din_p0;
        else if (state == CH_CAPTURE)
            words[cnt] <= din_p0;
    end

    assign full = (state == CH_FULL);
endmodule

// File: rtl/core_dout_mux.sv
// Collects packets from N_CORES channels and streams them one at a time to a single
// consumer, picking among full channels in round-robin order.
module core_dout_mux
    import core_dout_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int DW          = 4,
    parameter int LONG_WORDS  = 6,
    parameter int SHORT_WORDS = core_dout_pkg::SHORT_WORDS
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic [N_CORES*DW-1:0]                        core_dout_in,
    output logic [N_CORES-1:0]                           core_dout_ready,
    output logic [DW-1:0]                                dout,
    output logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] dout_core,
    output logic                                         dout_last,
    output logic                                         empty,
    input  logic                                         rd_en,
    output logic [N_CORES-1:0]                           err_core_dout
);
    localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int WW = $clog2(LONG_WORDS);

    logic [N_CORES-1:0]                ch_full;
    logic [N_CORES-1:0]                ch_rel;
    logic [N_CORES-1:0]                ch_long;
    logic [LONG_WORDS-1:0][DW-1:0]     ch_words [N_CORES];

    logic          busy;
    logic [CW-1:0] cur;
    logic [WW-1:0] widx;
    logic [CW-1:0] last_srv;
    logic [WW-1:0] last_idx;
    logic [CW-1:0] cand;
    logic [CW-1:0] gnt_idx;
    logic          gnt_vld;

    for (genvar g = 0; g < N_CORES; g++) begin : g_ch
        core_dout_capture #(
            .DW          (DW),
            .LONG_WORDS  (LONG_WORDS),
            .SHORT_WORDS (SHORT_WORDS)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .din     (core_dout_in[g*DW +: DW]),
            .rel     (ch_rel[g]),
            .full    (ch_full[g]),
            .ready   (core_dout_ready[g]),
            .err     (err_core_dout[g]),
            .is_long (ch_long[g]),
            .words   (ch_words[g])
        );
    end

    assign last_idx = ch_long[cur] ? WW'(LONG_WORDS - 1) : WW'(SHORT_WORDS - 1);

    always_comb begin
        ch_rel = '0;
        if (busy && rd_en && widx == last_idx)
            ch_rel[cur] = 1'b1;
    end

    // Scan from farthest to nearest so the nearest full channel after last_srv wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_CORES; k >= 1; k--) begin
            cand = CW'((int'(last_srv) + k) % N_CORES);
            if (ch_full[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy     <= 1'b0;
            cur      <= '0;
            widx     <= '0;
            last_srv <= CW'(N_CORES - 1);
        end else if (busy) begin
            if (rd_en) begin
                if (widx == last_idx) begin
                    busy     <= 1'b0;
                    last_srv <= cur;
                end else begin
                    widx <= widx + WW'(1);
                end
            end
        end else if (gnt_vld) begin
            busy <= 1'b1;
            cur  <= gnt_idx;
            widx <= '0;
        end
    end

    assign dout      = ch_words[cur][widx];
    assign dout_core = cur;
    assign dout_last = busy && (widx == last_idx);
    assign empty     = !busy;
endmodule
